vbsc_scan_ctrl: RTL and testbench
=================================

// Module: vbsc_scan_ctrl
// PURPOSE
//   Sequences the virtual boundary-scan chain: takes one scan command from a host, drives
//   one full capture -> shift -> (update) pass on the chain strobes and returns the shifted-out
//   vector. Sits between the host/command logic and the VBSC chain.
//   Replaces manual virtual-JTAG stepping for in-fabric self-test of the IO pins.
// PARAMETERS
//   VBSC_NUM   4   number of boundary-scan cells (pins) in the chain
//   VBSC_NBIT  3   bits per cell (inj, oej, outj)
//   CHAIN_LEN  VBSC_NUM*VBSC_NBIT (localparam, derived; not overridable)
// PORTS
//   tck        in   1          single clock; all logic on posedge tck
//   rst_n      in   1          synchronous, active-low reset
//   cmd_valid  in   1          command request
//   cmd_ready  out  1          command accepted when cmd_valid & cmd_ready at posedge
//   cmd_op     in   2          00 SAMPLE, 01 EXTEST, 1x reserved
//   cmd_vec    in   CHAIN_LEN  vector to shift into chain (EXTEST only)
//   rsp_valid  out  1          response available; held until rsp_ready
//   rsp_ready  in   1          response consumed when rsp_valid & rsp_ready at posedge
//   rsp_vec    out  CHAIN_LEN  captured vector shifted out of chain
//   rsp_err    out  1          1 = reserved op, no scan performed
//   scan_cdr   out  1          capture strobe to chain
//   scan_sdr   out  1          shift strobe to chain
//   scan_udr   out  1          update strobe to chain
//   scan_tdi   out  1          serial data into chain
//   scan_tdo   in   1          serial data out of chain (combinational from chain)
//   busy       out  1          1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE; cmd_ready=1 after reset released; rsp_valid=0,
//     rsp_vec=0, rsp_err=0, scan_cdr/sdr/udr=0, scan_tdi=0, busy=0. Reset mid-scan aborts at
//     that edge: strobes low next cycle, no update strobe issued, no response produced.
//   All outputs registered. cmd_ready = (state==IDLE). Command latched (op, vec) on accept.
//   FSM: IDLE -> CAPTURE -> SHIFT -> EXIT -> [UPDATE] -> RESP -> IDLE.
//     IDLE:    wait for accept. Reserved op -> RESP directly, rsp_err=1, rsp_vec=0, no strobes.
//     CAPTURE: 1 cycle, scan_cdr=1.
//     SHIFT:   exactly CHAIN_LEN cycles, scan_sdr=1; counter k=0..CHAIN_LEN-1,
//              width clog2(CHAIN_LEN+1), no wrap beyond CHAIN_LEN-1.
//              scan_tdi = cmd_vec[k] (LSB first) for EXTEST, 0 for SAMPLE.
//              rsp_vec[k] <= scan_tdo sampled at the posedge ending shift cycle k.
//     EXIT:    1 cycle, all strobes low (chain loads shift data on sdr falling).
//     UPDATE:  EXTEST only, 1 cycle, scan_udr=1. SAMPLE skips to RESP.
//     RESP:    rsp_valid=1; rsp_vec/rsp_err stable; leaves on rsp_valid&rsp_ready.
//   Strobes mutually exclusive; never two high in the same cycle.
//   Latency accept -> rsp_valid high: SAMPLE CHAIN_LEN+3 cycles, EXTEST CHAIN_LEN+4,
//     reserved 1 cycle.
//   Back-to-back: new command accepted earliest the cycle after RESP handshake (IDLE).
//   cmd_valid while busy is ignored (not queued); cmd_vec changes after accept have no effect.
//   rsp_ready held high while not in RESP: no effect.
// TESTING
//   Reset mid-SHIFT (k=5) -> next cycle all strobes 0, busy=0, cmd_ready=1, no udr ever seen.
//   SAMPLE, chain model preloaded 12'hA5C -> cdr 1 cycle, sdr 12 cycles, tdi=0, no udr;
//     rsp_vec=12'hA5C, rsp_valid 15 cycles after accept.
//   EXTEST cmd_vec=12'h3F1 on chain holding 12'h000 -> tdi bits LSB first 1,0,0,0,1,1..; udr
//     1 cycle after EXIT; chain update regs = 12'h3F1; rsp_vec=12'h000; latency 16.
//   Reserved op 2'b10 -> rsp_valid next cycle, rsp_err=1, rsp_vec=0, no strobes toggle.
//   rsp_ready=0 for 20 cycles -> rsp_valid/rsp_vec stable, cmd_ready=0; cmd_valid pulses ignored.
//   Two EXTESTs back-to-back with rsp_ready=1 -> second accepted 1 cycle after first RESP;
//     strobe sequences never overlap.

Source files
------------

// File: rtl/vbsc_scan_ctrl.sv
// vbsc_scan_ctrl: runs one capture -> shift -> exit -> (update) pass on the
// virtual boundary-scan chain per host command and returns the shifted-out vector.
module vbsc_scan_ctrl #(
  parameter  int VBSC_NUM  = 4,
  parameter  int VBSC_NBIT = 3,
  localparam int CHAIN_LEN = VBSC_NUM * VBSC_NBIT
) (
  input  logic                 tck,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_vec,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_vec,
  output logic                 rsp_err,
  output logic                 scan_cdr,
  output logic                 scan_sdr,
  output logic                 scan_udr,
  output logic                 scan_tdi,
  input  logic                 scan_tdo,
  output logic                 busy
);

  localparam int            KW     = $clog2(CHAIN_LEN + 1);
  localparam logic [KW-1:0] K_LAST = KW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_SHIFT, S_EXIT, S_UPDATE, S_RESP
  } state_t;

  state_t                 r_state;
  state_t                 w_nxt;
  logic [KW-1:0]          r_k;
  logic                   r_ext;
  logic [CHAIN_LEN-1:0]   r_vec;
  logic [CHAIN_LEN-1:0]   r_rsp_vec;
  logic                   r_rsp_err;
  logic                   r_cmd_ready;
  logic                   r_rsp_valid;
  logic                   r_cdr;
  logic                   r_sdr;
  logic                   r_udr;
  logic                   r_tdi;
  logic                   r_busy;
  logic                   w_accept;
  logic                   w_tdi;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  // Next-state decode plus the serial bit to present in the upcoming shift cycle
  always_comb begin
    w_nxt = r_state;
    w_tdi = 1'b0;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_nxt = cmd_op[1] ? S_RESP : S_CAPTURE;
      S_CAPTURE: w_nxt = S_SHIFT;
      S_SHIFT:   if (r_k == K_LAST) w_nxt = S_EXIT;
      S_EXIT:    w_nxt = r_ext ? S_UPDATE : S_RESP;
      S_UPDATE:  w_nxt = S_RESP;
      S_RESP:    if (rsp_ready) w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
    // tdi is registered, so pick the bit for shift index k one edge early (LSB first)
    if (w_nxt == S_SHIFT && r_ext) begin
      if (r_state == S_CAPTURE) w_tdi = r_vec[0];
      else                      w_tdi = r_vec[r_k + 1'b1];
    end
  end

  // State register; reset aborts any scan in progress
  always_ff @(posedge tck) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Registered outputs decoded from the next state so strobes align with their state
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_tdi       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_nxt == S_IDLE);
      r_rsp_valid <= (w_nxt == S_RESP);
      r_cdr       <= (w_nxt == S_CAPTURE);
      r_sdr       <= (w_nxt == S_SHIFT);
      r_udr       <= (w_nxt == S_UPDATE);
      r_tdi       <= w_tdi;
      r_busy      <= (w_nxt != S_IDLE);
    end
  end

  // Shift counter: restarts at 0 each scan and parks on the last index
  always_ff @(posedge tck) begin
    if (!rst_n)                                r_k <= '0;
    else if (r_state == S_CAPTURE)             r_k <= '0;
    else if (r_state == S_SHIFT && r_k != K_LAST) r_k <= r_k + 1'b1;
  end

  // Command latch and response assembly; tdo bit k lands at the edge ending shift cycle k
  always_ff @(posedge tck) begin
    if (w_accept) begin
      r_ext <= (cmd_op == 2'b01);
      r_vec <= cmd_vec;
    end
    if (!rst_n) begin
      r_rsp_vec <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_rsp_vec <= '0;
      r_rsp_err <= cmd_op[1];
    end else if (r_state == S_SHIFT) begin
      r_rsp_vec[r_k] <= scan_tdo;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_vec   = r_rsp_vec;
  assign rsp_err   = r_rsp_err;
  assign scan_cdr  = r_cdr;
  assign scan_sdr  = r_sdr;
  assign scan_udr  = r_udr;
  assign scan_tdi  = r_tdi;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vbsc_scan_ctrl.sv
// tb_vbsc_scan_ctrl: directed bench with a behavioural boundary-scan chain model.
module tb_vbsc_scan_ctrl;

  localparam int N = 12;

  logic         tck = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_vec;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_vec;
  logic         rsp_err;
  logic         scan_cdr, scan_sdr, scan_udr, scan_tdi, scan_tdo;
  logic         busy;

  always #5 tck = ~tck;

  vbsc_scan_ctrl #(.VBSC_NUM(4), .VBSC_NBIT(3)) dut (
    .tck(tck), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_vec(cmd_vec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vec(rsp_vec), .rsp_err(rsp_err),
    .scan_cdr(scan_cdr), .scan_sdr(scan_sdr), .scan_udr(scan_udr),
    .scan_tdi(scan_tdi), .scan_tdo(scan_tdo), .busy(busy)
  );

  // Chain model: capture pins, shift toward bit 0 (tdo), update latches shift register
  logic [N-1:0] pins = '0;
  logic [N-1:0] sr   = '0;
  logic [N-1:0] ur   = '0;
  assign scan_tdo = sr[0];
  always @(posedge tck) begin
    if (scan_cdr)      sr <= pins;
    else if (scan_sdr) sr <= {scan_tdi, sr[N-1:1]};
    if (scan_udr)      ur <= sr;
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  int           lat, n_cdr, n_sdr, n_udr, udr_cyc, overlap;
  logic [N-1:0] tdi_seq;
  logic         rdy_issue;

  // Issue one command at a negedge, then observe strobes each negedge until rsp_valid
  task automatic do_cmd(input logic [1:0] op, input logic [N-1:0] vec);
    int cyc;
    lat = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; udr_cyc = 0; overlap = 0; tdi_seq = '0;
    @(negedge tck);
    rdy_issue = cmd_ready;
    cmd_valid = 1'b1; cmd_op = op; cmd_vec = vec;
    @(posedge tck);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_vec = ~vec;
    cyc = 0;
    while (lat == 0 && cyc < 100) begin
      @(negedge tck);
      cyc++;
      if (scan_cdr) n_cdr++;
      if (scan_sdr) begin
        if (n_sdr < N) tdi_seq[n_sdr] = scan_tdi;
        n_sdr++;
      end
      if (scan_udr) begin
        n_udr++;
        udr_cyc = cyc;
      end
      if (int'(scan_cdr) + int'(scan_sdr) + int'(scan_udr) > 1) overlap++;
      if (rsp_valid) lat = cyc;
    end
  endtask

  int           stall_bad, post_bad;
  logic [N-1:0] ur_keep;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_vec = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge tck);
    @(negedge tck);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({scan_cdr, scan_sdr, scan_udr, scan_tdi}), 32'd0);
    chk("rst_rvec", 32'(rsp_vec), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    // SAMPLE of pins A5C; cmd_vec must not reach tdi
    pins = 12'hA5C;
    do_cmd(2'b00, 12'hFFF);
    chk("smp_issue_rdy", 32'(rdy_issue), 32'd1);
    chk("smp_lat", 32'(lat), 32'd15);
    chk("smp_cdr", 32'(n_cdr), 32'd1);
    chk("smp_sdr", 32'(n_sdr), 32'd12);
    chk("smp_udr", 32'(n_udr), 32'd0);
    chk("smp_tdi", 32'(tdi_seq), 32'd0);
    chk("smp_overlap", 32'(overlap), 32'd0);
    chk("smp_rvec", 32'(rsp_vec), 32'hA5C);
    chk("smp_err", 32'(rsp_err), 32'd0);
    chk("smp_busy", 32'(busy), 32'd1);

    // Hold off the response for 20 cycles while pulsing cmd_valid
    stall_bad = 0;
    repeat (20) begin
      @(negedge tck);
      if (!rsp_valid || rsp_vec !== 12'hA5C || cmd_ready || scan_cdr) stall_bad++;
      cmd_valid = ~cmd_valid; cmd_op = 2'b01;
    end
    @(negedge tck);
    cmd_valid = 1'b0;
    chk("stall_stable", 32'(stall_bad), 32'd0);
    chk("stall_rvalid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge tck);
    chk("hs_rvalid", 32'(rsp_valid), 32'd0);
    chk("hs_ready", 32'(cmd_ready), 32'd1);
    chk("hs_busy", 32'(busy), 32'd0);

    // EXTEST 3F1 into a chain whose pins read 000
    pins = 12'h000;
    do_cmd(2'b01, 12'h3F1);
    chk("ext_lat", 32'(lat), 32'd16);
    chk("ext_tdi", 32'(tdi_seq), 32'h3F1);
    chk("ext_cdr", 32'(n_cdr), 32'd1);
    chk("ext_sdr", 32'(n_sdr), 32'd12);
    chk("ext_udr", 32'(n_udr), 32'd1);
    chk("ext_udr_cyc", 32'(udr_cyc), 32'd15);
    chk("ext_overlap", 32'(overlap), 32'd0);
    chk("ext_update", 32'(ur), 32'h3F1);
    chk("ext_rvec", 32'(rsp_vec), 32'h000);

    // Reserved op: immediate error response, no strobes
    do_cmd(2'b10, 12'hFFF);
    chk("rsv_issue_rdy", 32'(rdy_issue), 32'd1);
    chk("rsv_lat", 32'(lat), 32'd1);
    chk("rsv_err", 32'(rsp_err), 32'd1);
    chk("rsv_rvec", 32'(rsp_vec), 32'd0);
    chk("rsv_strobes", 32'(n_cdr + n_sdr + n_udr), 32'd0);

    // Two EXTESTs back to back with rsp_ready held high
    pins = 12'hC3A;
    do_cmd(2'b01, 12'h5A3);
    chk("b2b1_lat", 32'(lat), 32'd16);
    chk("b2b1_err", 32'(rsp_err), 32'd0);
    chk("b2b1_rvec", 32'(rsp_vec), 32'hC3A);
    chk("b2b1_update", 32'(ur), 32'h5A3);
    pins = 12'h18E;
    do_cmd(2'b01, 12'h0F0);
    chk("b2b2_issue_rdy", 32'(rdy_issue), 32'd1);
    chk("b2b2_lat", 32'(lat), 32'd16);
    chk("b2b2_overlap", 32'(overlap), 32'd0);
    chk("b2b2_cdr", 32'(n_cdr), 32'd1);
    chk("b2b2_rvec", 32'(rsp_vec), 32'h18E);
    chk("b2b2_update", 32'(ur), 32'h0F0);

    // Reset during shift cycle k=5 of an EXTEST
    ur_keep = ur;
    @(negedge tck);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_vec = 12'hFFF;
    @(posedge tck);
    #1;
    cmd_valid = 1'b0;
    repeat (7) @(negedge tck);
    chk("mid_in_shift", 32'(scan_sdr), 32'd1);
    rst_n = 1'b0;
    @(negedge tck);
    chk("mid_strobes", 32'({scan_cdr, scan_sdr, scan_udr}), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rvalid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    post_bad = 0;
    repeat (25) begin
      @(negedge tck);
      if (scan_udr || rsp_valid || busy || scan_sdr) post_bad++;
    end
    chk("mid_quiet", 32'(post_bad), 32'd0);
    chk("mid_update_kept", 32'(ur), 32'(ur_keep));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
